// File: rtl/tacho_scheduler.sv
// Periodic tachometer sampling sequencer: strobes each channel, captures its signed delta,
// accumulates position and streams {ch, delta, pos}. Define STALL_DETECT_EN for per-channel stall flags.
module tacho_scheduler #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PER_W      = 24,
    parameter int unsigned STROBE_LEN = 4,
    parameter int unsigned SETTLE_LEN = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PER_W-1:0]     period,
    output logic [NCH-1:0]       tach_read,
    input  logic [NCH*CNT_W-1:0] tach_cnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2:0]           out_ch,
    output logic [CNT_W-1:0]     out_delta,
    output logic [CNT_W-1:0]     out_pos,
    input  logic [NCH-1:0]       pos_clr,
    output logic                 overrun,
    input  logic                 overrun_clr
`ifdef STALL_DETECT_EN
    ,
    input  logic [7:0]           stall_limit,
    output logic [NCH-1:0]       stall
`endif
);

    localparam int unsigned CH_W   = 3;
    localparam int unsigned PH_MAX = (STROBE_LEN > SETTLE_LEN) ? STROBE_LEN : SETTLE_LEN;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {IDLE, STROBE, SETTLE, CAPTURE, OUTPUT} state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  ch, ch_nxt;
    logic [PH_W-1:0]  ph, ph_nxt;
    logic [PER_W-1:0] timer, timer_nxt;
    logic             run, tick, capture;

    logic [NCH-1:0]   tach_read_nxt;
    logic             out_valid_nxt;
    logic [CH_W-1:0]  out_ch_nxt;
    logic [CNT_W-1:0] out_delta_nxt, out_pos_nxt;
    logic             overrun_nxt;

    logic [CNT_W-1:0] pos     [NCH];
    logic [CNT_W-1:0] pos_nxt [NCH];
    logic [CNT_W-1:0] delta, pos_sel, pos_sum;
    logic             clr_sel;

    // Sample-period timer; wraps modulo 2^PER_W if period is lowered below the current count
    always_comb begin
        run       = enable && (period != '0);
        tick      = run && (timer == period - PER_W'(1));
        timer_nxt = '0;
        if (run && !tick) begin
            timer_nxt = timer + PER_W'(1);
        end
    end

    // Current channel's count slice and its post-capture position (clear applies before add)
    always_comb begin
        delta   = '0;
        pos_sel = '0;
        clr_sel = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch == CH_W'(i)) begin
                delta   = tach_cnt[i*CNT_W +: CNT_W];
                pos_sel = pos[i];
                clr_sel = pos_clr[i];
            end
        end
        pos_sum = (clr_sel ? '0 : pos_sel) + delta;
    end

    always_comb begin
        state_nxt     = state;
        ch_nxt        = ch;
        ph_nxt        = ph;
        capture       = 1'b0;
        out_valid_nxt = out_valid;
        out_ch_nxt    = out_ch;
        out_delta_nxt = out_delta;
        out_pos_nxt   = out_pos;

        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = STROBE;
                    ch_nxt    = '0;
                    ph_nxt    = '0;
                end
            end
            STROBE: begin
                if (ph == PH_W'(STROBE_LEN - 1)) begin
                    state_nxt = SETTLE;
                    ph_nxt    = '0;
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            SETTLE: begin
                if (ph == PH_W'(SETTLE_LEN - 1)) begin
                    state_nxt = CAPTURE;
                    ph_nxt    = '0;
                end else begin
                    ph_nxt = ph + PH_W'(1);
                end
            end
            CAPTURE: begin
                capture       = 1'b1;
                out_valid_nxt = 1'b1;
                out_ch_nxt    = ch;
                out_delta_nxt = delta;
                out_pos_nxt   = pos_sum;
                state_nxt     = OUTPUT;
            end
            OUTPUT: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (ch == CH_W'(NCH - 1)) begin
                        state_nxt = IDLE;
                    end else begin
                        ch_nxt    = ch + CH_W'(1);
                        ph_nxt    = '0;
                        state_nxt = STROBE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Strobe is a function of the next state so it is high for exactly the STROBE cycles
        tach_read_nxt = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            tach_read_nxt[i] = (state_nxt == STROBE) && (ch_nxt == CH_W'(i));
        end

        // A tick that cannot start a round is dropped and flagged; set beats clear
        overrun_nxt = overrun;
        if (tick && (state != IDLE)) begin
            overrun_nxt = 1'b1;
        end else if (overrun_clr) begin
            overrun_nxt = 1'b0;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            pos_nxt[i] = pos_clr[i] ? '0 : pos[i];
            if (capture && (ch == CH_W'(i))) begin
                pos_nxt[i] = pos_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ch        <= '0;
            ph        <= '0;
            timer     <= '0;
            tach_read <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_delta <= '0;
            out_pos   <= '0;
            overrun   <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                pos[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            ch        <= ch_nxt;
            ph        <= ph_nxt;
            timer     <= timer_nxt;
            tach_read <= tach_read_nxt;
            out_valid <= out_valid_nxt;
            out_ch    <= out_ch_nxt;
            out_delta <= out_delta_nxt;
            out_pos   <= out_pos_nxt;
            overrun   <= overrun_nxt;
            for (int unsigned i = 0; i < NCH; i++) begin
                pos[i] <= pos_nxt[i];
            end
        end
    end

`ifdef STALL_DETECT_EN
    logic [7:0]     stall_cnt     [NCH];
    logic [7:0]     stall_cnt_nxt [NCH];
    logic [NCH-1:0] stall_nxt;

    // Saturating run length of zero-delta captures per channel
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            stall_cnt_nxt[i] = pos_clr[i] ? '0 : stall_cnt[i];
            if (capture && (ch == CH_W'(i))) begin
                if (delta != '0) begin
                    stall_cnt_nxt[i] = '0;
                end else if (stall_cnt_nxt[i] != 8'hFF) begin
                    stall_cnt_nxt[i] = stall_cnt_nxt[i] + 8'd1;
                end
            end
            stall_nxt[i] = (stall_limit != '0) && (stall_cnt_nxt[i] >= stall_limit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                stall_cnt[i] <= '0;
            end
        end else begin
            stall <= stall_nxt;
            for (int unsigned i = 0; i < NCH; i++) begin
                stall_cnt[i] <= stall_cnt_nxt[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_tacho_scheduler.sv
// Self-checking bench for tacho_scheduler: slot-timing reference model compared every cycle,
// plus hand-computed record, timing and boundary expectations.
module tb_tacho_scheduler;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned PER_W = 24;
    localparam int unsigned SL    = 4;
    localparam int unsigned TL    = 4;

    logic                 clk         = 1'b0;
    logic                 reset       = 1'b1;
    logic                 enable      = 1'b0;
    logic [PER_W-1:0]     period      = '0;
    logic [NCH-1:0]       tach_read;
    logic [NCH*CNT_W-1:0] tach_cnt    = '0;
    logic                 out_valid;
    logic                 out_ready   = 1'b1;
    logic [2:0]           out_ch;
    logic [CNT_W-1:0]     out_delta;
    logic [CNT_W-1:0]     out_pos;
    logic [NCH-1:0]       pos_clr     = '0;
    logic                 overrun;
    logic                 overrun_clr = 1'b0;
`ifdef STALL_DETECT_EN
    logic [7:0]           stall_limit = 8'd0;
    logic [NCH-1:0]       stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    tacho_scheduler #(
        .NCH(NCH), .CNT_W(CNT_W), .PER_W(PER_W), .STROBE_LEN(SL), .SETTLE_LEN(TL)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .tach_read(tach_read), .tach_cnt(tach_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_delta(out_delta), .out_pos(out_pos), .pos_clr(pos_clr),
        .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef STALL_DETECT_EN
        , .stall_limit(stall_limit), .stall(stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A round is busy from its tick to the last handshake; m_t is the cycle index inside a slot
    logic [PER_W-1:0] m_timer = '0;
    bit               m_tick  = 0;
    bit               m_busy  = 0;
    bit               m_valid = 0;
    bit               m_ovr   = 0;
    int               m_ch    = 0;
    int               m_t     = 0;
    logic [2:0]       m_out_ch  = '0;
    logic [CNT_W-1:0] m_delta   = '0;
    logic [CNT_W-1:0] m_out_pos = '0;
    logic [CNT_W-1:0] m_pos [NCH];
    logic [NCH-1:0]   m_read  = '0;
`ifdef STALL_DETECT_EN
    int               m_scnt [NCH];
    logic [NCH-1:0]   m_stall = '0;
`endif

    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_timer = '0; m_busy = 0; m_valid = 0; m_ovr = 0; m_ch = 0; m_t = 0;
            m_out_ch = '0; m_delta = '0; m_out_pos = '0;
            for (int i = 0; i < NCH; i++) m_pos[i] = '0;
`ifdef STALL_DETECT_EN
            for (int i = 0; i < NCH; i++) m_scnt[i] = 0;
            m_stall = '0;
`endif
        end else begin
            m_tick = enable && (period != '0) && (m_timer == period - 24'd1);
            if (!enable || period == '0 || m_tick) m_timer = '0;
            else m_timer = m_timer + 24'd1;
            if (m_tick && m_busy) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
            for (int i = 0; i < NCH; i++) begin
                if (pos_clr[i]) begin
                    m_pos[i] = '0;
`ifdef STALL_DETECT_EN
                    m_scnt[i] = 0;
`endif
                end
            end
            if (!m_busy) begin
                if (m_tick) begin m_busy = 1; m_ch = 0; m_t = 0; end
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 0;
                    if (m_ch == int'(NCH) - 1) m_busy = 0;
                    else begin m_ch++; m_t = 0; end
                end
            end else if (m_t == int'(SL + TL)) begin
                m_delta     = tach_cnt[m_ch*CNT_W +: CNT_W];
                m_pos[m_ch] = m_pos[m_ch] + m_delta;
                m_out_pos   = m_pos[m_ch];
                m_out_ch    = 3'(m_ch);
                m_valid     = 1;
`ifdef STALL_DETECT_EN
                if (m_delta != 0) m_scnt[m_ch] = 0;
                else if (m_scnt[m_ch] < 255) m_scnt[m_ch]++;
`endif
            end else begin
                m_t++;
            end
`ifdef STALL_DETECT_EN
            for (int i = 0; i < NCH; i++)
                m_stall[i] = (stall_limit != 0) && (m_scnt[i] >= int'(stall_limit));
`endif
        end
        m_read = (m_busy && !m_valid && m_t < int'(SL)) ? (NCH'(1) << m_ch) : '0;
    end

    // ---------------- per-cycle compare and record log ----------------
    typedef struct { logic [2:0] ch; logic [CNT_W-1:0] d; logic [CNT_W-1:0] p; } rec_t;
    rec_t rq[$];
    int   read0_cnt  = 0;
    int   first_rise = -1;

    initial forever begin
        @(negedge clk);
        chk("read",    64'(tach_read), 64'(m_read));
        chk("valid",   64'(out_valid), 64'(m_valid));
        chk("ch",      64'(out_ch),    64'(m_out_ch));
        chk("delta",   64'(out_delta), 64'(m_delta));
        chk("pos",     64'(out_pos),   64'(m_out_pos));
        chk("overrun", 64'(overrun),   64'(m_ovr));
`ifdef STALL_DETECT_EN
        chk("stall",   64'(stall),     64'(m_stall));
`endif
        if (out_valid && out_ready && !reset) rq.push_back('{out_ch, out_delta, out_pos});
        if (tach_read[0]) begin
            read0_cnt++;
            if (first_rise < 0) first_rise = cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic set_counts(input int c0, input int c1, input int c2, input int c3);
        tach_cnt = {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
    endtask

    task automatic wait_recs(input int n, input int budget);
        int k = 0;
        while (rq.size() < n && k < budget) begin @(negedge clk); k++; end
        chk($sformatf("recs_%0d", n), 64'(rq.size() >= n), 64'(1));
    endtask

    task automatic wait_read(input int c, input int budget);
        int k = 0;
        while (!tach_read[c] && k < budget) begin @(negedge clk); k++; end
        chk($sformatf("read%0d_seen", c), 64'(tach_read[c]), 64'(1));
    endtask

    task automatic wait_valid_ch(input int c, input int budget);
        int k = 0;
        while (!(out_valid && out_ch == 3'(c)) && k < budget) begin @(negedge clk); k++; end
        chk($sformatf("valid_ch%0d_seen", c), 64'(out_valid && out_ch == 3'(c)), 64'(1));
    endtask

    task automatic chk_rec(input int idx, input int c, input logic [31:0] d, input logic [31:0] p);
        if (idx < rq.size()) begin
            chk($sformatf("rec%0d_ch", idx),    64'(rq[idx].ch), 64'(c));
            chk($sformatf("rec%0d_delta", idx), 64'(rq[idx].d),  64'(d));
            chk($sformatf("rec%0d_pos", idx),   64'(rq[idx].p),  64'(p));
        end else begin
            chk($sformatf("rec%0d_present", idx), 64'(rq.size()), 64'(idx + 1));
        end
    endtask

    // ---------------- directed sequence ----------------
    int             en_cyc;
    int             base;
    logic [NCH-1:0] rd_seen;
    logic           v_seen;

    initial begin
        set_counts(5, -3, 0, 7);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_read",  64'(tach_read), 64'(0));
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_pos",   64'(out_pos),   64'(0));
        chk("reset_ovr",   64'(overrun),   64'(0));

        // Two identical rounds at period 100
        @(posedge clk); #1;
        period = 24'd100; enable = 1'b1; en_cyc = cyc;
        wait_recs(4, 200);
        chk("first_rise_latency", 64'(first_rise - en_cyc), 64'(100));
        chk("read0_high_cycles",  64'(read0_cnt),           64'(4));
        chk_rec(0, 0, 5, 5);
        chk_rec(1, 1, -3, -3);
        chk_rec(2, 2, 0, 0);
        chk_rec(3, 3, 7, 7);
        wait_recs(8, 200);
        chk_rec(4, 0, 5, 10);
        chk_rec(5, 1, -3, -6);
        chk_rec(6, 2, 0, 0);
        chk_rec(7, 3, 7, 14);

        // Consumer stall on ch1 while a shorter period forces an overrun
        wait_valid_ch(0, 200);
        @(posedge clk); #1;
        out_ready = 1'b0; period = 24'd40;
        wait_valid_ch(1, 50);
        rd_seen = '0;
        repeat (50) begin @(negedge clk); rd_seen |= tach_read; end
        chk("stall_no_read",  64'(rd_seen),   64'(0));
        chk("stall_ch",       64'(out_ch),    64'(1));
        chk("stall_delta",    64'(out_delta), 64'(32'hFFFF_FFFD));
        chk("stall_pos",      64'(out_pos),   64'(32'hFFFF_FFF7));
        chk("overrun_set",    64'(overrun),   64'(1));
        @(posedge clk); #1;
        enable = 1'b0; overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", 64'(overrun), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_recs(12, 100);
        chk_rec(9, 1, -3, -9);
        chk_rec(11, 3, 7, 21);

        // Position wrap, then clear coinciding with capture
        @(posedge clk); #1;
        pos_clr = 4'b0001;
        @(posedge clk); #1;
        pos_clr = '0;
        set_counts(32'h7FFF_FFFF, 0, 0, 0);
        period = 24'd60; enable = 1'b1;
        wait_recs(16, 200);
        chk_rec(12, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        chk_rec(13, 1, 0, -9);
        @(posedge clk); #1;
        set_counts(1, 0, 0, 0);
        wait_recs(20, 200);
        chk_rec(16, 0, 1, 32'h8000_0000);
        @(posedge clk); #1;
        set_counts(4, 0, 0, 0);
        wait_read(0, 100);
        repeat (8) @(posedge clk);
        #1 pos_clr = 4'b0001;
        @(posedge clk); #1;
        pos_clr = '0;
        wait_recs(24, 100);
        chk_rec(20, 0, 4, 4);

        // Enable falls during ch1 strobe: round still completes, then silence
        wait_read(1, 100);
        @(posedge clk); #1;
        enable = 1'b0;
        wait_recs(28, 100);
        chk_rec(24, 0, 4, 8);
        chk_rec(25, 1, 0, -9);
        chk_rec(27, 3, 0, 21);
        @(posedge clk);
        rd_seen = '0; v_seen = 1'b0;
        repeat (200) begin @(negedge clk); rd_seen |= tach_read; v_seen |= out_valid; end
        chk("disable_no_read",  64'(rd_seen), 64'(0));
        chk("disable_no_valid", 64'(v_seen),  64'(0));

        // Reset asserted during SETTLE
        @(posedge clk); #1;
        enable = 1'b1;
        wait_read(0, 100);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_read",  64'(tach_read), 64'(0));
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_ch",    64'(out_ch),    64'(0));
        chk("rst_mid_delta", 64'(out_delta), 64'(0));
        chk("rst_mid_pos",   64'(out_pos),   64'(0));
        chk("rst_mid_ovr",   64'(overrun),   64'(0));
        @(posedge clk); #1;
        reset = 1'b0; enable = 1'b0;

        // period = 0 never schedules a round
        @(posedge clk); #1;
        period = '0; enable = 1'b1;
        rd_seen = '0; v_seen = 1'b0;
        repeat (1000) begin @(negedge clk); rd_seen |= tach_read; v_seen |= out_valid; end
        chk("period0_no_read",  64'(rd_seen), 64'(0));
        chk("period0_no_valid", 64'(v_seen),  64'(0));
        @(posedge clk); #1;
        enable = 1'b0;

`ifdef STALL_DETECT_EN
        // ch2 reports zero delta for three rounds, then moves
        @(posedge clk); #1;
        stall_limit = 8'd3; period = 24'd60;
        set_counts(1, 1, 0, 1);
        enable = 1'b1;
        base = rq.size();
        wait_recs(base + 8, 300);
        chk("stall_after_2", 64'(stall), 64'(0));
        wait_recs(base + 12, 200);
        chk("stall_after_3", 64'(stall), 64'(4'b0100));
        @(posedge clk); #1;
        set_counts(1, 1, 1, 1);
        wait_recs(base + 16, 200);
        chk("stall_released", 64'(stall), 64'(0));
        @(posedge clk); #1;
        enable = 1'b0;
`endif

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sequence did not complete by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
